lz77_encoder: RTL and testbench

Streaming LZ77 encoder that sits directly upstream of LZ77_Decoder. It consumes a byte stream of hex-digit characters terminated by '$' (8'h24) and emits (code_pos, code_len, char_nxt) triples. Field widths and encoding match what LZ77_Decoder consumes. The search buffer holds 9 entries and the look-ahead buffer holds 8.

---
 rtl/lz77_pkg.sv | 32 +++
 rtl/lz77_match_len.sv | 30 +++
 rtl/lz77_encoder.sv | 179 +++++++++++++++++
 tb/tb_lz77_encoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// Shared widths, FSM states and triple payload for the LZ77 encoder.
package lz77_pkg;
    localparam int unsigned SB_DEPTH = 9;
    localparam int unsigned LA_DEPTH = 8;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned POS_W    = 4;
    localparam int unsigned LEN_W    = 3;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WIN_D    = SB_DEPTH + LA_DEPTH;
    localparam logic [DATA_W-1:0] TERM = 8'h24;

    typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] nxt;
    } triple_t;

    // Longest allowed match so that a literal always follows it.
    function automatic logic [LEN_W-1:0] len_cap(input logic [CNT_W-1:0] la_cnt);
        logic [LEN_W-1:0] cap;
        if (la_cnt >= CNT_W'(LA_DEPTH)) begin
            cap = LEN_W'(LA_DEPTH - 1);
        end else if (la_cnt == '0) begin
            cap = '0;
        end else begin
            cap = LEN_W'(la_cnt - CNT_W'(1));
        end
        return cap;
    endfunction
endpackage

// File: rtl/lz77_match_len.sv
// Match length of one search-buffer candidate against the look-ahead, overlap allowed.
module lz77_match_len
    import lz77_pkg::*;
(
    input  logic [DATA_W-1:0] win_i [WIN_D],
    input  logic [POS_W-1:0]  pos_i,
    input  logic              vld_i,
    input  logic [LEN_W-1:0]  cap_i,
    output logic [LEN_W-1:0]  len_o
);
    logic [DATA_W-1:0] src;
    logic              run;

    // Source index walks from SB[pos] towards and into the look-ahead.
    always_comb begin
        len_o = '0;
        run   = vld_i;
        for (int unsigned j = 0; j < LA_DEPTH - 1; j++) begin
            src = '0;
            for (int unsigned k = 0; k < WIN_D; k++) begin
                if (k + 32'(pos_i) == SB_DEPTH - 1 + j) src = win_i[k];
            end
            if (run && (LEN_W'(j) < cap_i) && (src == win_i[SB_DEPTH + j])) begin
                len_o = len_o + LEN_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: fills look-ahead, scans search buffer one candidate per cycle, emits triples.
module lz77_encoder
    import lz77_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] chardata,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              out_ready,
    output logic              valid,
    output logic              encode,
    output logic [POS_W-1:0]  code_pos,
    output logic [LEN_W-1:0]  code_len,
    output logic [DATA_W-1:0] char_nxt,
    output logic              finish
);
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sb_q [SB_DEPTH];
    logic [DATA_W-1:0]   sb_d [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;
    logic [DATA_W-1:0]   la_q [LA_DEPTH];
    logic [DATA_W-1:0]   la_d [LA_DEPTH];
    logic [CNT_W-1:0]    la_cnt_q, la_cnt_d;
    logic                term_q, term_d;
    logic [POS_W-1:0]    cand_q, cand_d;
    logic [POS_W-1:0]    best_pos_q, best_pos_d;
    logic [LEN_W-1:0]    best_len_q, best_len_d;
    logic [LEN_W-1:0]    shift_q, shift_d;
    triple_t             out_q, out_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                encode_q, encode_d;
    logic                finish_q, finish_d;

    logic [DATA_W-1:0]   win_c [WIN_D];
    logic                cand_vld_c;
    logic [LEN_W-1:0]    cand_len_c;
    logic [LEN_W-1:0]    cap_c;

    // Window is oldest SB entry first, then look-ahead in order.
    always_comb begin
        for (int unsigned k = 0; k < SB_DEPTH; k++) win_c[k] = sb_q[SB_DEPTH - 1 - k];
        for (int unsigned j = 0; j < LA_DEPTH; j++) win_c[SB_DEPTH + j] = la_q[j];
        cand_vld_c = 1'b0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            if (POS_W'(k) == cand_q) cand_vld_c = sb_vld_q[k];
        end
    end

    assign cap_c = len_cap(la_cnt_q);

    lz77_match_len u_match_len (
        .win_i (win_c),
        .pos_i (cand_q),
        .vld_i (cand_vld_c),
        .cap_i (cap_c),
        .len_o (cand_len_c)
    );

    always_comb begin
        state_d    = state_q;
        sb_d       = sb_q;
        sb_vld_d   = sb_vld_q;
        la_d       = la_q;
        la_cnt_d   = la_cnt_q;
        term_d     = term_q;
        cand_d     = cand_q;
        best_pos_d = best_pos_q;
        best_len_d = best_len_q;
        shift_d    = shift_q;
        out_d      = out_q;
        valid_d    = valid_q;
        encode_d   = 1'b1;
        unique case (state_q)
            FILL: begin
                if (char_valid && ready_q) begin
                    for (int unsigned k = 0; k < LA_DEPTH; k++) begin
                        if (CNT_W'(k) == la_cnt_q) la_d[k] = chardata;
                    end
                    la_cnt_d = la_cnt_q + CNT_W'(1);
                    if (chardata == TERM) term_d = 1'b1;
                end
                if ((la_cnt_d == CNT_W'(LA_DEPTH)) || term_d) begin
                    state_d    = SEARCH;
                    cand_d     = '0;
                    best_pos_d = '0;
                    best_len_d = '0;
                end
            end
            SEARCH: begin
                // Strictly longer wins, so ties keep the smaller distance.
                if (cand_len_c > best_len_q) begin
                    best_pos_d = cand_q;
                    best_len_d = cand_len_c;
                end
                if (cand_q == POS_W'(SB_DEPTH - 1)) begin
                    state_d   = EMIT;
                    valid_d   = 1'b1;
                    out_d.pos = best_pos_d;
                    out_d.len = best_len_d;
                    for (int unsigned k = 0; k < LA_DEPTH; k++) begin
                        if (LEN_W'(k) == best_len_d) out_d.nxt = la_q[k];
                    end
                end else begin
                    cand_d = cand_q + POS_W'(1);
                end
            end
            EMIT: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    shift_d = out_q.len;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sb_d[0]  = la_q[0];
                for (int unsigned k = 1; k < SB_DEPTH; k++) sb_d[k] = sb_q[k - 1];
                sb_vld_d = {sb_vld_q[SB_DEPTH-2:0], 1'b1};
                for (int unsigned k = 0; k < LA_DEPTH - 1; k++) la_d[k] = la_q[k + 1];
                la_d[LA_DEPTH-1] = '0;
                la_cnt_d = la_cnt_q - CNT_W'(1);
                if (shift_q == '0) begin
                    state_d = (out_q.nxt == TERM) ? DONE : FILL;
                end else begin
                    shift_d = shift_q - LEN_W'(1);
                end
            end
            DONE: state_d = DONE;
            default: state_d = FILL;
        endcase
        finish_d = (state_d == DONE);
        ready_d  = (state_d == FILL) && (la_cnt_d < CNT_W'(LA_DEPTH)) && !term_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FILL;
            sb_q       <= '{default: '0};
            sb_vld_q   <= '0;
            la_q       <= '{default: '0};
            la_cnt_q   <= '0;
            term_q     <= 1'b0;
            cand_q     <= '0;
            best_pos_q <= '0;
            best_len_q <= '0;
            shift_q    <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            encode_q   <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            sb_vld_q   <= sb_vld_d;
            la_q       <= la_d;
            la_cnt_q   <= la_cnt_d;
            term_q     <= term_d;
            cand_q     <= cand_d;
            best_pos_q <= best_pos_d;
            best_len_q <= best_len_d;
            shift_q    <= shift_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            encode_q   <= encode_d;
            finish_q   <= finish_d;
        end
    end

    assign char_ready = ready_q;
    assign valid      = valid_q;
    assign encode     = encode_q;
    assign code_pos   = out_q.pos;
    assign code_len   = out_q.len;
    assign char_nxt   = out_q.nxt;
    assign finish     = finish_q;
endmodule

// File: tb/tb_lz77_encoder.sv
// Scoreboard bench for lz77_encoder: directed strings plus random strings against a string-level model.
module tb_lz77_encoder;
    typedef byte bq_t[$];
    typedef logic [14:0] trip_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] chardata = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       out_ready = 1'b1;
    logic       valid;
    logic       encode;
    logic [3:0] code_pos;
    logic [2:0] code_len;
    logic [7:0] char_nxt;
    logic       finish;

    int    checks = 0;
    int    passed = 0;
    trip_t exp_q[$];
    int    accepted = 0;
    int    stall_idx = -1;
    int    stall_left = 0;
    int    rdy_pct = 100;
    string hexd = "0123456789ABCDEF";

    logic  prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b0;
    trip_t prev_t = '0, cur_t, e_t;

    always #5 clk = ~clk;

    lz77_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .chardata   (chardata),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .out_ready  (out_ready),
        .valid      (valid),
        .encode     (encode),
        .code_pos   (code_pos),
        .code_len   (code_len),
        .char_nxt   (char_nxt),
        .finish     (finish)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic bq_t s2q(input string str);
        bq_t q;
        for (int i = 0; i < str.len(); i++) q.push_back(byte'(str[i]));
        return q;
    endfunction

    function automatic void exp3(input int pos, input int len, input byte c);
        exp_q.push_back({4'(pos), 3'(len), 8'(c)});
    endfunction

    // Greedy LZ77 over the whole string: look-ahead holds min(8, remaining) chars.
    function automatic void model(input bq_t s);
        int n, p, la, cap, bl, bp, l, st;
        n = s.size();
        p = 0;
        while (p < n) begin
            la  = (n - p < 8) ? n - p : 8;
            cap = (la - 1 < 7) ? la - 1 : 7;
            bl  = 0;
            bp  = 0;
            for (int pos = 0; pos < 9; pos++) begin
                st = p - 1 - pos;
                if (st >= 0) begin
                    l = 0;
                    while (l < cap && s[st + l] == s[p + l]) l++;
                    if (l > bl) begin
                        bl = l;
                        bp = pos;
                    end
                end
            end
            exp3(bp, bl, s[p + bl]);
            p += bl + 1;
        end
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks hold-stability under back-pressure.
    always @(negedge clk) begin
        cur_t = {code_pos, code_len, char_nxt};
        if (prev_rst && prev_v && !prev_r) begin
            check("hold_valid", 32'(valid), 32'd1);
            check("hold_fields", 32'(cur_t), 32'(prev_t));
        end
        if (reset && valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_triple", 32'(cur_t), 32'hFFFF_FFFF);
            end else begin
                e_t = exp_q.pop_front();
                check("triple", 32'(cur_t), 32'(e_t));
            end
            accepted++;
        end
        prev_v   = valid;
        prev_r   = out_ready;
        prev_rst = reset;
        prev_t   = cur_t;
    end

    // Downstream back-pressure: random, with an optional forced stall on a chosen triple.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && valid && accepted == stall_idx) begin
                out_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        char_valid = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        exp_q.delete();
        accepted = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_encode"}, 32'(encode), 32'd0);
        check({tag, "_finish"}, 32'(finish), 32'd0);
        check({tag, "_char_ready"}, 32'(char_ready), 32'd0);
        check({tag, "_fields"}, 32'({code_pos, code_len, char_nxt}), 32'd0);
    endtask

    // Drives a string; rst_at_search>0 aborts with reset in SEARCH cycle 4 after TERM is taken.
    task automatic run_str(input bq_t s, input int rst_at_search);
        int n, idx, cyc, junk;
        bit done;
        n    = s.size();
        idx  = 0;
        cyc  = 0;
        junk = 0;
        done = 1'b0;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (finish) begin
                done       = 1'b1;
                char_valid = 1'b0;
            end else begin
                if (idx < n) begin
                    chardata   = s[idx];
                    char_valid = ($urandom_range(0, 3) != 0);
                end else begin
                    chardata   = (($urandom_range(0, 4) == 0) ? 8'h24 : 8'(hexd[$urandom_range(0, 15)]));
                    char_valid = ($urandom_range(0, 1) != 0);
                end
                @(negedge clk);
                if (char_valid && char_ready) begin
                    if (idx < n) begin
                        idx++;
                        if (rst_at_search > 0 && idx == n) begin
                            @(posedge clk);
                            #1;
                            char_valid = 1'b0;
                            repeat (3) @(posedge clk);
                            #1;
                            reset = 1'b0;
                            @(posedge clk);
                            #1;
                            reset = 1'b1;
                            @(negedge clk);
                            check_all_zero("mid_search_reset");
                            check("mid_search_no_triple", 32'(accepted), 32'd0);
                            return;
                        end
                    end else begin
                        junk++;
                    end
                end
            end
        end
        check("finish_seen", 32'(done), 32'd1);
        check("leftover_triples", 32'(exp_q.size()), 32'd0);
        check("after_term_accepts", 32'(junk), 32'd0);
        repeat (2) @(negedge clk);
        check("done_finish", 32'(finish), 32'd1);
        check("done_encode", 32'(encode), 32'd1);
        check("done_valid", 32'(valid), 32'd0);
        check("done_char_ready", 32'(char_ready), 32'd0);
    endtask

    initial begin
        bq_t s;
        int  len, lim;
        // Reset state
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        rdy_pct = 100;
        exp3(0, 0, "0"); exp3(0, 0, "1"); exp3(0, 0, "2"); exp3(0, 0, "3"); exp3(0, 0, "$");
        run_str(s2q("0123$"), 0);
        do_reset();

        exp3(0, 0, "0"); exp3(0, 3, "$");
        run_str(s2q("0000$"), 0);
        do_reset();

        exp3(0, 0, "0"); exp3(0, 0, "1"); exp3(1, 3, "$");
        run_str(s2q("01010$"), 0);
        do_reset();

        exp3(0, 0, "0"); exp3(0, 7, "0"); exp3(0, 2, "$");
        run_str(s2q("00000000000$"), 0);
        do_reset();

        exp3(0, 0, "$");
        run_str(s2q("$"), 0);
        do_reset();

        // Five-cycle stall on the second triple
        stall_idx  = 1;
        stall_left = 5;
        exp3(0, 0, "0"); exp3(0, 0, "1"); exp3(0, 0, "2"); exp3(0, 0, "3"); exp3(0, 0, "$");
        run_str(s2q("0123$"), 0);
        check("stall_consumed", 32'(stall_left), 32'd0);
        stall_idx = -1;
        do_reset();

        // Reset in the middle of SEARCH, then a clean rerun
        run_str(s2q("0123$"), 1);
        exp3(0, 0, "0"); exp3(0, 0, "1"); exp3(0, 0, "2"); exp3(0, 0, "3"); exp3(0, 0, "$");
        run_str(s2q("0123$"), 0);
        do_reset();

        rdy_pct = 60;
        for (int r = 0; r < 20; r++) begin
            s.delete();
            len = $urandom_range(0, 32);
            case ($urandom_range(0, 2))
                0:       lim = 1;
                1:       lim = 3;
                default: lim = 15;
            endcase
            for (int i = 0; i < len; i++) s.push_back(byte'(hexd[$urandom_range(0, lim)]));
            s.push_back(8'h24);
            model(s);
            run_str(s, 0);
            do_reset();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
